// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
//   Shared definitions for the CNN datapath blocks.
//   PIX_W          : default feature-map pixel width.
//   unpool_state_t : row phase of the 2x unpooling stage.
//                    ROW_A = even output row (input accepted, pixels recorded)
//                    ROW_B = odd output row (replayed from the line buffer)
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam int PIX_W = 16;

  typedef enum logic {
    ROW_A = 1'b0,
    ROW_B = 1'b1
  } unpool_state_t;

endpackage : cnn_pkg

// File: rtl/line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
//   One input row of pixels, written during the even output row and read back
//   during the odd output row of the 2x unpooler.
//   Ports:
//     clk    in   clock, write on rising edge
//     we     in   write enable
//     waddr  in   write column
//     wdata  in   pixel to store
//     raddr  in   read column
//     rdata  out  stored pixel at raddr (combinational)
// -----------------------------------------------------------------------------
module line_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 14,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: storage arrays carry no reset; every entry is written before it is
  // read back, and leaving reset off keeps this a plain register file.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule : line_buffer

// File: rtl/unpool_2x.sv
// -----------------------------------------------------------------------------
// unpool_2x
//   Nearest-neighbour 2x upsampler. Each raster-order input pixel becomes a
//   2x2 output block: the even output row shows every pixel twice as it
//   arrives, the odd output row replays the same row from a line buffer.
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset
//     in_valid   in   input pixel valid
//     in_ready   out  input pixel accepted this cycle when high with in_valid
//     in_pix     in   input pixel
//     out_valid  out  output pixel valid (registered)
//     out_ready  in   downstream accepts output pixel
//     out_pix    out  output pixel (registered)
//     out_sof    out  first output pixel of a frame
//     out_eol    out  last pixel of an output row
// -----------------------------------------------------------------------------
module unpool_2x
  import cnn_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int IN_W   = 14,
  parameter int IN_H   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pix,
  output logic              out_sof,
  output logic              out_eol
);

  localparam int COL_W = $clog2(IN_W);
  localparam int ROW_W = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);

  unpool_state_t     state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              rep_q, rep_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_pix_q, out_pix_d;
  logic              out_sof_q, out_sof_d;
  logic              out_eol_q, out_eol_d;

  logic              adv;
  logic              in_fire;
  logic              col_last;
  logic [DATA_W-1:0] buf_rdata;

  // The output slot may be (re)loaded when empty or when being drained.
  assign adv      = !out_valid_q || out_ready;
  assign col_last = (col_q == COL_LAST);

  // New input only fills the first copy of an even-row pixel, so a stalled
  // output or a pending second copy holds off the producer.
  assign in_ready = !rst && adv && (state_q == ROW_A) && !rep_q;
  assign in_fire  = in_valid && in_ready;

  line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IN_W),
    .ADDR_W (COL_W)
  ) u_line_buffer (
    .clk   (clk),
    .we    (in_fire),
    .waddr (col_q),
    .wdata (in_pix),
    .raddr (col_q),
    .rdata (buf_rdata)
  );

  // NOTE: every _d gets its _q as a default first, so no path through the
  // case below leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    rep_d       = rep_q;
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;

    case (state_q)
      ROW_A: begin
        if (!rep_q) begin
          if (in_fire) begin
            out_pix_d   = in_pix;
            out_valid_d = 1'b1;
            rep_d       = 1'b1;
            out_sof_d   = (row_q == '0) && (col_q == '0);
            out_eol_d   = 1'b0;
          end else if (adv) begin
            out_valid_d = 1'b0;
            out_sof_d   = 1'b0;
            out_eol_d   = 1'b0;
          end
        end else if (adv) begin
          // Second copy: pixel register is left as is.
          rep_d     = 1'b0;
          out_sof_d = 1'b0;
          out_eol_d = col_last;
          if (col_last) begin
            col_d   = '0;
            state_d = ROW_B;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      ROW_B: begin
        if (adv) begin
          out_pix_d   = buf_rdata;
          out_valid_d = 1'b1;
          rep_d       = !rep_q;
          out_sof_d   = 1'b0;
          out_eol_d   = rep_q && col_last;
          if (rep_q) begin
            if (col_last) begin
              col_d   = '0;
              state_d = ROW_A;
              row_d   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end

      default: state_d = ROW_A;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ROW_A;
      col_q       <= '0;
      row_q       <= '0;
      rep_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      rep_q       <= rep_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;

endmodule : unpool_2x

// File: tb/tb_unpool_2x.sv
// -----------------------------------------------------------------------------
// tb_unpool_2x
//   Self-checking bench for unpool_2x. Random frames are pushed through the
//   DUT; the expected output stream is built from the 2x2 replication rule
//   (row r of the input appears as output rows 2r and 2r+1, every pixel twice).
// -----------------------------------------------------------------------------
module tb_unpool_2x;

  localparam int DW = 16;
  localparam int W  = 6;
  localparam int H  = 3;
  localparam int FRAME_OUT = 4 * W * H;

  typedef struct packed {
    logic [DW-1:0] pix;
    logic          sof;
    logic          eol;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pix;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_pix;
  logic          out_sof;
  logic          out_eol;

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] src_q[$];
  exp_t          exp_q[$];
  int            sof_idx[$];
  int            mon_runs;
  int            mon_gaps;
  logic          gap_ov;
  logic          gap_rdy;

  always #5 clk = ~clk;

  unpool_2x #(
    .DATA_W (DW),
    .IN_W   (W),
    .IN_H   (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
  );

  // Reference model: queue the input frame and its expected 2x2 expansion.
  task automatic add_frame(input bit special);
    logic [DW-1:0] f[W*H];
    for (int i = 0; i < W * H; i++) f[i] = DW'($urandom);
    if (special) begin
      f[1]         = 16'hFFFF;
      f[2]         = 16'h0000;
      f[W*H-1]     = 16'hFFFF;
      f[W]         = 16'h0000;
    end
    for (int i = 0; i < W * H; i++) src_q.push_back(f[i]);
    for (int r = 0; r < H; r++)
      for (int rr = 0; rr < 2; rr++)
        for (int c = 0; c < W; c++)
          for (int k = 0; k < 2; k++)
            exp_q.push_back('{pix: f[r*W+c],
                              sof: (r == 0 && rr == 0 && c == 0 && k == 0),
                              eol: (c == W - 1 && k == 1)});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Producer: offers src_q in order; optionally idles 3 cycles before pixel gap_idx.
  task automatic run_driver(input int gap_idx, input int budget);
    int  cyc = 0;
    int  i = 0;
    bit  gap_done = 0;
    while (src_q.size() > 0) begin
      if (i == gap_idx && !gap_done) begin
        gap_done = 1;
        repeat (3) begin
          @(posedge clk); #1;
          in_valid = 1'b0;
          @(negedge clk);
        end
        gap_ov  = out_valid;
        gap_rdy = in_ready;
      end
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_pix   = src_q[0];
      @(negedge clk);
      cyc++;
      if (in_ready) begin
        void'(src_q.pop_front());
        i++;
      end
      if (cyc >= budget) begin
        n_total++;
        $display("FAIL driver_timeout pixels_left=%0d required=0", src_q.size());
        src_q.delete();
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Consumer/scoreboard: drives out_ready, compares every transfer with exp_q,
  // checks that a stalled output does not move, and logs in_ready low runs.
  task automatic run_monitor(input bit bp, input bit chk_runs, input int budget);
    int            cyc = 0;
    int            idx = 0;
    int            lowrun = 0;
    bit            held = 0;
    bit            started = 0;
    logic [DW-1:0] h_pix;
    logic          h_sof, h_eol;
    exp_t          e;
    mon_runs = 0;
    mon_gaps = 0;
    sof_idx.delete();
    while (exp_q.size() > 0 && cyc < budget) begin
      @(posedge clk); #1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
      if (held) begin
        n_total++;
        if (out_valid !== 1'b1 || out_pix !== h_pix || out_sof !== h_sof || out_eol !== h_eol)
          $display("FAIL stall_hold idx=%0d actual v=%b pix=%h sof=%b eol=%b required v=1 pix=%h sof=%b eol=%b",
                   idx, out_valid, out_pix, out_sof, out_eol, h_pix, h_sof, h_eol);
        else
          n_pass++;
      end
      if (chk_runs) begin
        if (in_ready !== 1'b1) begin
          lowrun++;
        end else begin
          // Row end: second copy of the last pixel, then 2*W replay cycles.
          if (lowrun > 1) begin
            mon_runs++;
            n_total++;
            if (lowrun != 2 * W + 1)
              $display("FAIL in_ready_low_run actual=%0d required=%0d", lowrun, 2 * W + 1);
            else
              n_pass++;
          end
          lowrun = 0;
        end
      end
      if (started && out_valid !== 1'b1) mon_gaps++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        started = 1;
        e = exp_q.pop_front();
        n_total++;
        if ({out_pix, out_sof, out_eol} !== {e.pix, e.sof, e.eol})
          $display("FAIL out_stream idx=%0d actual pix=%h sof=%b eol=%b required pix=%h sof=%b eol=%b",
                   idx, out_pix, out_sof, out_eol, e.pix, e.sof, e.eol);
        else
          n_pass++;
        if (out_sof === 1'b1) sof_idx.push_back(idx);
        idx++;
      end
      held  = (out_valid === 1'b1) && (out_ready !== 1'b1);
      h_pix = out_pix;
      h_sof = out_sof;
      h_eol = out_eol;
    end
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL monitor_timeout outputs_missing=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    #1 out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_pix = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({out_valid, out_sof, out_eol} !== 3'b000)
      $display("FAIL reset_flags actual v/sof/eol=%b required=000", {out_valid, out_sof, out_eol});
    else n_pass++;
    n_total++;
    if (out_pix !== '0) $display("FAIL reset_pix actual=%h required=0000", out_pix);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready actual=%b required=0", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL idle_in_ready actual=%b required=1", in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    add_frame(1'b0);
    fork
      run_driver(-1, 4000);
      run_monitor(1'b0, 1'b1, 4000);
    join
    n_total++;
    if (mon_runs != H) $display("FAIL row_replay_count actual=%0d required=%0d", mon_runs, H);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    add_frame(1'b1);
    add_frame(1'b0);
    fork
      run_driver(-1, 8000);
      run_monitor(1'b1, 1'b0, 8000);
    join
  endtask

  task automatic test_gaps();
    do_reset();
    add_frame(1'b0);
    fork
      run_driver(1, 4000);
      run_monitor(1'b0, 1'b0, 4000);
    join
    n_total++;
    if (gap_ov !== 1'b0) $display("FAIL gap_out_valid actual=%b required=0", gap_ov);
    else n_pass++;
    n_total++;
    if (gap_rdy !== 1'b1) $display("FAIL gap_in_ready actual=%b required=1", gap_rdy);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL spurious_output actual=%b required=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    int cyc = 0;
    do_reset();
    while (acc < 5 && cyc < 100) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_pix   = DW'($urandom);
      @(negedge clk);
      cyc++;
      if (in_ready) acc++;
    end
    n_total++;
    if (acc != 5) $display("FAIL mid_accept actual=%0d required=5", acc);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL mid_rst_in_ready actual=%b required=0", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({out_valid, out_sof, out_eol} !== 3'b000 || out_pix !== '0)
      $display("FAIL mid_rst_out actual v/sof/eol=%b pix=%h required=000 pix=0000",
               {out_valid, out_sof, out_eol}, out_pix);
    else n_pass++;
    add_frame(1'b0);
    fork
      run_driver(-1, 4000);
      run_monitor(1'b0, 1'b0, 4000);
    join
    n_total++;
    if (sof_idx.size() != 1 || sof_idx[0] != 0)
      $display("FAIL mid_rst_sof actual_count=%0d required_count=1 at 0", sof_idx.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    add_frame(1'b0);
    add_frame(1'b0);
    fork
      run_driver(-1, 8000);
      run_monitor(1'b0, 1'b0, 8000);
    join
    n_total++;
    if (sof_idx.size() != 2) $display("FAIL b2b_sof_count actual=%0d required=2", sof_idx.size());
    else n_pass++;
    n_total++;
    if (sof_idx.size() != 2 || sof_idx[0] != 0 || sof_idx[1] != FRAME_OUT)
      $display("FAIL b2b_sof_index actual_second=%0d required=%0d",
               (sof_idx.size() > 1) ? sof_idx[1] : -1, FRAME_OUT);
    else n_pass++;
    n_total++;
    if (mon_gaps != 0) $display("FAIL b2b_continuous actual_gaps=%0d required=0", mon_gaps);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_unpool_2x
